watch_cu: RTL and testbench
===========================

Name: watch_cu

Overview:
- Control unit sitting directly upstream of the watch datapath.
- Turns debounced level buttons (mode/up/down) into single-cycle adjust ticks for the hour, minute and second counters.
- Tracks the time-set state machine and returns to run mode on idle timeout.
- Drives edit status and a blink strobe for the display controller.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- TIMEOUT_SEC, 10, idle seconds in a set state before auto-return to RUN.
- BLINK_HALF, 50_000_000, clock cycles per blink half-period.
- REPEAT_DELAY, 50_000_000, hold cycles before auto-repeat starts (AUTOREPEAT_EN only).
- REPEAT_PERIOD, 10_000_000, cycles between auto-repeat ticks (AUTOREPEAT_EN only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_mode  in  1  debounced mode button, level.
- btn_up  in  1  debounced up button, level.
- btn_down  in  1  debounced down button, level.
- tick_hour_up  out  1  one-cycle increment of hour counter.
- tick_min_up  out  1  one-cycle increment of minute counter.
- tick_sec_up  out  1  one-cycle increment of second counter.
- tick_hour_down  out  1  one-cycle decrement of hour counter.
- tick_min_down  out  1  one-cycle decrement of minute counter.
- tick_sec_down  out  1  one-cycle decrement of second counter.
- edit_mode  out  1  high in any set state.
- sel_field  out  2  state code: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
- blink  out  1  field-blink strobe for display.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state RUN, all tick outputs 0, edit_mode 0, sel_field 0, blink 0, all counters 0.
- Button previous-value registers reset to 1, so a button held through reset release is not a press.
- Press detection: a press is btn & ~btn_prev, evaluated at a clk edge. All outputs are registered.
  - A resulting tick is high for exactly the one cycle after that edge (latency 1 cycle).
  - Holding a button produces no further ticks unless AUTOREPEAT_EN is defined.
- FSM on mode press: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  - edit_mode and sel_field update in the same cycle the state changes.
- In RUN: up/down presses are ignored; no ticks are issued.
- In SET_x: an up press pulses tick_x_up; a down press pulses tick_x_down. Only the selected field is ticked. Wrap-around is handled downstream.
- Simultaneous events:
  - mode press together with up or down: mode wins, no tick is issued.
  - up and down pressed on the same edge: both ignored, no tick, but the idle timer is still cleared.
- Idle timeout:
  - The idle counter runs only in set states. It clears on any button press and on every state change.
  - When it reaches TIMEOUT_SEC*CLK_HZ-1, the next edge forces RUN. No tick is issued on that edge.
  - Counter width is $clog2(TIMEOUT_SEC*CLK_HZ).
- Blink:
  - In RUN, blink = 0 and the blink counter is held at 0.
  - On entering any set state, the blink counter restarts and blink = 1.
  - blink toggles every BLINK_HALF cycles.
  - Any up/down press forces blink = 1 and restarts the blink counter.
- Reset mid-operation: immediate return to RUN, any pending tick is dropped, all outputs take reset values asynchronously.
- At most one tick output is high in any cycle.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- Defined: in a set state, while exactly one of up/down stays high after its press tick:
  - After REPEAT_DELAY cycles, one extra tick for the same field/direction is emitted.
  - Further ticks follow every REPEAT_PERIOD cycles.
  - Each repeat tick clears the idle timer and forces blink = 1.
  - Release, mode press, state change or the second direction button going high stops the repeat and resets the repeat counter.
- Not defined: no repeat logic is synthesised; holding a button yields only the single press tick.

Test Plan (bench params: CLK_HZ=100, TIMEOUT_SEC=2, BLINK_HALF=10, REPEAT_DELAY=20, REPEAT_PERIOD=5):
- Reset with btn_up held, release reset, keep btn_up high 50 cycles -> no ticks, sel_field=0, blink=0.
- 4 mode presses -> sel_field 1,2,3,0 in order, edit_mode 1,1,1,0. An up press in RUN -> no tick.
- In SET_MIN, press up then down -> tick_min_up for exactly 1 cycle the cycle after the edge, then tick_min_down for 1 cycle. Hour and second ticks stay 0.
- In SET_HOUR, mode and up rise on the same edge -> sel_field=2, no tick. Up and down rise on the same edge -> no tick.
- In SET_SEC, idle 199 cycles -> still SET_SEC. At the 200th edge -> sel_field=0, edit_mode=0, blink=0.
  - An up press at idle cycle 150 restarts the count.
- With AUTOREPEAT_EN, in SET_HOUR hold btn_up 40 cycles -> ticks at cycle 1, 21, 26, 31, 36 (5 ticks).
  - Without the macro -> exactly 1 tick.

Source files
------------

// File: rtl/watch_cu.sv
// watch_cu: button presses -> one-cycle adjust ticks (1-cycle latency, registered), set-mode FSM with idle timeout and blink.
// No backpressure. Define AUTOREPEAT_EN to add hold-to-repeat ticks; without it a held button gives one tick.
module watch_cu #(
   parameter int CLK_HZ        = 100_000_000,
   parameter int TIMEOUT_SEC   = 10,
   parameter int BLINK_HALF    = 50_000_000,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic       tick_hour_up,
   output logic       tick_min_up,
   output logic       tick_sec_up,
   output logic       tick_hour_down,
   output logic       tick_min_down,
   output logic       tick_sec_down,
   output logic       edit_mode,
   output logic [1:0] sel_field,
   output logic       blink
);
   typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_t;

   localparam int IDLE_W = $clog2(TIMEOUT_SEC * CLK_HZ);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_SEC * CLK_HZ - 1);
   localparam int BLINK_W = $clog2(BLINK_HALF + 1);
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF - 1);

   state_t             state_q, state_d;
   logic               mode_prev_q, up_prev_q, down_prev_q;
   logic [IDLE_W-1:0]  idle_q, idle_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_q, blink_d;
   logic               edit_q;
   logic [5:0]         tick_q, tick_d;

   logic mode_p, up_p, down_p, in_set, timeout, adj_ok, inc, dec;
   logic rpt_fire, rpt_up;
   logic [2:0] fsel;

`ifdef AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] DELAY_MAX  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_MAX = RPT_W'(REPEAT_PERIOD - 1);

   logic             rpt_arm_q, rpt_arm_d, rpt_up_q, rpt_up_d, rpt_fast_q, rpt_fast_d;
   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_hold;
`endif

   always_comb begin
      mode_p  = btn_mode & ~mode_prev_q;
      up_p    = btn_up & ~up_prev_q;
      down_p  = btn_down & ~down_prev_q;
      in_set  = (state_q != RUN);
      timeout = in_set && (idle_q == IDLE_MAX);

      state_d = state_q;
      if (timeout)
         state_d = RUN;
      else if (mode_p)
         state_d = state_t'(state_q + 2'd1);

      // Mode and timeout both pre-empt adjustment; simultaneous up+down cancel out.
      adj_ok = in_set && !timeout && !mode_p;
      inc    = adj_ok && up_p && !down_p;
      dec    = adj_ok && down_p && !up_p;

      rpt_fire = 1'b0;
      rpt_up   = 1'b0;
`ifdef AUTOREPEAT_EN
      rpt_hold   = rpt_up_q ? (btn_up & ~btn_down) : (btn_down & ~btn_up);
      rpt_arm_d  = 1'b0;
      rpt_up_d   = rpt_up_q;
      rpt_fast_d = 1'b0;
      rpt_cnt_d  = '0;
      if (inc || dec) begin
         rpt_arm_d = 1'b1;
         rpt_up_d  = inc;
      end else if (rpt_arm_q && adj_ok && rpt_hold) begin
         rpt_arm_d  = 1'b1;
         rpt_fast_d = rpt_fast_q;
         if (rpt_cnt_q == (rpt_fast_q ? PERIOD_MAX : DELAY_MAX)) begin
            rpt_fire   = 1'b1;
            rpt_fast_d = 1'b1;
         end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
         end
      end
      rpt_up = rpt_up_q;
`endif

      fsel   = {state_q == SET_SEC, state_q == SET_MIN, state_q == SET_HOUR};
      tick_d = '0;
      if (inc || (rpt_fire && rpt_up))
         tick_d[2:0] = fsel;
      if (dec || (rpt_fire && !rpt_up))
         tick_d[5:3] = fsel;

      if (state_d == RUN || state_d != state_q || mode_p || up_p || down_p || rpt_fire)
         idle_d = '0;
      else
         idle_d = idle_q + 1'b1;

      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q + 1'b1;
      if (state_d == RUN) begin
         blink_d     = 1'b0;
         blink_cnt_d = '0;
      end else if (state_d != state_q || (adj_ok && (up_p || down_p)) || rpt_fire) begin
         blink_d     = 1'b1;
         blink_cnt_d = '0;
      end else if (blink_cnt_q == BLINK_MAX) begin
         blink_d     = ~blink_q;
         blink_cnt_d = '0;
      end
   end

   // Previous-value registers reset high so a button held through reset is not a press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         mode_prev_q <= 1'b1;
         up_prev_q   <= 1'b1;
         down_prev_q <= 1'b1;
         idle_q      <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
         edit_q      <= 1'b0;
         tick_q      <= '0;
      end else begin
         state_q     <= state_d;
         mode_prev_q <= btn_mode;
         up_prev_q   <= btn_up;
         down_prev_q <= btn_down;
         idle_q      <= idle_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
         edit_q      <= (state_d != RUN);
         tick_q      <= tick_d;
      end
   end

`ifdef AUTOREPEAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rpt_arm_q  <= 1'b0;
         rpt_up_q   <= 1'b0;
         rpt_fast_q <= 1'b0;
         rpt_cnt_q  <= '0;
      end else begin
         rpt_arm_q  <= rpt_arm_d;
         rpt_up_q   <= rpt_up_d;
         rpt_fast_q <= rpt_fast_d;
         rpt_cnt_q  <= rpt_cnt_d;
      end
   end
`endif

   assign tick_hour_up   = tick_q[0];
   assign tick_min_up    = tick_q[1];
   assign tick_sec_up    = tick_q[2];
   assign tick_hour_down = tick_q[3];
   assign tick_min_down  = tick_q[4];
   assign tick_sec_down  = tick_q[5];
   assign edit_mode      = edit_q;
   assign sel_field      = state_q;
   assign blink          = blink_q;

endmodule

// File: tb/tb_watch_cu.sv
// Directed bench for watch_cu: expected ticks are queued with their due cycle and checked by a negedge monitor.
module tb_watch_cu;
   logic       clk, reset, btn_mode, btn_up, btn_down;
   logic       tick_hour_up, tick_min_up, tick_sec_up;
   logic       tick_hour_down, tick_min_down, tick_sec_down;
   logic       edit_mode, blink;
   logic [1:0] sel_field;

   localparam logic [5:0] HOUR_UP = 6'b000001;
   localparam logic [5:0] MIN_UP  = 6'b000010;
   localparam logic [5:0] SEC_UP  = 6'b000100;
   localparam logic [5:0] MIN_DN  = 6'b010000;

   typedef struct {
      int         cyc;
      logic [5:0] code;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   logic [5:0] tv;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   int         c0;

   watch_cu #(
      .CLK_HZ(100), .TIMEOUT_SEC(2), .BLINK_HALF(10), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
   ) dut (
      .clk(clk), .reset(reset),
      .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
      .tick_hour_up(tick_hour_up), .tick_min_up(tick_min_up), .tick_sec_up(tick_sec_up),
      .tick_hour_down(tick_hour_down), .tick_min_down(tick_min_down), .tick_sec_down(tick_sec_down),
      .edit_mode(edit_mode), .sel_field(sel_field), .blink(blink)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [5:0] ticks();
      return {tick_sec_down, tick_min_down, tick_hour_down, tick_sec_up, tick_min_up, tick_hour_up};
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int c, input logic [5:0] code);
      sb.push_back('{c, code});
   endtask

   task automatic mode_press();
      btn_mode = 1'b1;
      step(1);
      btn_mode = 1'b0;
      step(1);
   endtask

   // Every tick seen must be the head of the queue and arrive on its due cycle.
   always @(negedge clk) begin
      if (!reset) begin
         tv = ticks();
         if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_chk++;
            assert ({tv, cyc} === {e.code, e.cyc}) else begin
               n_fail++;
               $error("FAIL tick_sb observed=%b@%0d expected=%b@%0d", tv, cyc, e.code, e.cyc);
            end
         end else if (tv !== 6'b0) begin
            n_chk++;
            assert (tv === 6'b0) else begin
               n_fail++;
               $error("FAIL tick_unexpected observed=%b@%0d expected=000000", tv, cyc);
            end
         end
      end
   end

   initial begin
      reset    = 1'b1;
      btn_mode = 1'b0;
      btn_up   = 1'b1;
      btn_down = 1'b0;
      step(2);
      chk("rst_sel", 32'(sel_field), 0);
      chk("rst_edit", 32'(edit_mode), 0);
      chk("rst_blink", 32'(blink), 0);
      chk("rst_ticks", 32'(ticks()), 0);

      // Button held through reset release is not a press.
      reset = 1'b0;
      step(50);
      chk("held_sel", 32'(sel_field), 0);
      chk("held_blink", 32'(blink), 0);
      chk("held_edit", 32'(edit_mode), 0);
      btn_up = 1'b0;
      step(2);

      for (int i = 1; i <= 4; i++) begin
         btn_mode = 1'b1;
         step(1);
         chk($sformatf("mode_sel_%0d", i), 32'(sel_field), i % 4);
         chk($sformatf("mode_edit_%0d", i), 32'(edit_mode), (i < 4) ? 1 : 0);
         if (i == 1) chk("enter_blink", 32'(blink), 1);
         btn_mode = 1'b0;
         step(1);
      end

      btn_up = 1'b1;
      step(1);
      btn_up = 1'b0;
      step(2);
      chk("run_up_sel", 32'(sel_field), 0);

      mode_press();
      mode_press();
      chk("setmin_sel", 32'(sel_field), 2);
      push(cyc + 1, MIN_UP);
      btn_up = 1'b1;
      step(1);
      btn_up = 1'b0;
      step(2);
      push(cyc + 1, MIN_DN);
      btn_down = 1'b1;
      step(1);
      chk("blink_press", 32'(blink), 1);
      btn_down = 1'b0;
      step(9);
      chk("blink_hold9", 32'(blink), 1);
      step(1);
      chk("blink_off10", 32'(blink), 0);
      step(10);
      chk("blink_on20", 32'(blink), 1);

      mode_press();
      mode_press();
      mode_press();
      chk("sethour_sel", 32'(sel_field), 1);
      btn_up   = 1'b1;
      btn_down = 1'b1;
      step(1);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      step(2);
      chk("updown_sel", 32'(sel_field), 1);
      btn_mode = 1'b1;
      btn_up   = 1'b1;
      step(1);
      chk("modeup_sel", 32'(sel_field), 2);
      btn_mode = 1'b0;
      btn_up   = 1'b0;
      step(2);

      btn_mode = 1'b1;
      step(1);
      chk("setsec_sel", 32'(sel_field), 3);
      btn_mode = 1'b0;
      step(149);
      push(cyc + 1, SEC_UP);
      btn_up = 1'b1;
      step(1);
      btn_up = 1'b0;
      step(198);
      chk("idle198_sel", 32'(sel_field), 3);
      step(1);
      chk("idle199_sel", 32'(sel_field), 3);
      step(1);
      chk("timeout_sel", 32'(sel_field), 0);
      chk("timeout_edit", 32'(edit_mode), 0);
      chk("timeout_blink", 32'(blink), 0);

      mode_press();
      c0 = cyc;
      push(c0 + 1, HOUR_UP);
`ifdef AUTOREPEAT_EN
      push(c0 + 21, HOUR_UP);
      push(c0 + 26, HOUR_UP);
      push(c0 + 31, HOUR_UP);
      push(c0 + 36, HOUR_UP);
`endif
      btn_up = 1'b1;
      step(40);
      btn_up = 1'b0;
      step(5);
      chk("hold_sel", 32'(sel_field), 1);

      // Asynchronous reset while a tick is on the outputs.
      btn_up = 1'b1;
      @(posedge clk);
      #1;
      chk("pre_rst_tick", 32'(tick_hour_up), 1);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_ticks", 32'(ticks()), 0);
      chk("arst_sel", 32'(sel_field), 0);
      chk("arst_edit", 32'(edit_mode), 0);
      chk("arst_blink", 32'(blink), 0);
      step(2);
      btn_up = 1'b0;
      reset  = 1'b0;
      step(3);
      chk("post_rst_sel", 32'(sel_field), 0);

      chk("sb_empty", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
